// File: rtl/nios2_onchip_mem_arbiter_if.sv
// Avalon-MM style requester port used by each side of the on-chip memory arbiter.
// The master modport is the requester's view; the slave modport is the arbiter's view.
interface nios2_onchip_mem_arbiter_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32,
   parameter int BE_W   = 4
);
   logic [ADDR_W-1:0] address;
   logic [BE_W-1:0]   byteenable;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;

   modport master (
      output address, byteenable, read, write, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, byteenable, read, write, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/nios2_onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip memory between two Avalon-MM requesters.
// Optionally zero-fills the memory after reset before granting any traffic.
module nios2_onchip_mem_arbiter #(
   parameter int ADDR_W         = 11,
   parameter int DATA_W         = 32,
   parameter int BE_W           = 4,
   parameter int DEPTH          = 2048,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   nios2_onchip_mem_arbiter_if.slave r0,
   nios2_onchip_mem_arbiter_if.slave r1,
   output logic [ADDR_W-1:0]     mem_address,
   output logic [BE_W-1:0]       mem_byteenable,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [DATA_W-1:0]     mem_writedata,
   output logic                  mem_clken,
   input  logic [DATA_W-1:0]     mem_readdata
);

   typedef enum logic {CLEAR, RUN} state_t;

   localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

   state_t            state, state_next;
   logic [ADDR_W-1:0] clr_cnt;
   logic              last_grant;
   logic              rd_pend;
   logic              rd_owner;
   logic              req0, req1;
   logic              grant_valid;
   logic              grant_sel;
   logic              grant_is_read;

   // grant_sel=1 selects r1; on contention the requester not served last wins
   always_comb begin
      req0          = r0.read | r0.write;
      req1          = r1.read | r1.write;
      grant_valid   = (state == RUN) && !reset && (req0 || req1);
      grant_sel     = req1 && (!req0 || !last_grant);
      grant_is_read = grant_sel ? (r1.read && !r1.write) : (r0.read && !r0.write);
   end

   always_comb begin
      state_next       = state;
      mem_address      = '0;
      mem_byteenable   = '0;
      mem_chipselect   = 1'b0;
      mem_write        = 1'b0;
      mem_writedata    = '0;
      mem_clken        = 1'b1;
      r0.waitrequest   = 1'b1;
      r1.waitrequest   = 1'b1;
      r0.readdata      = mem_readdata;
      r1.readdata      = mem_readdata;
      r0.readdatavalid = !reset && rd_pend && !rd_owner;
      r1.readdatavalid = !reset && rd_pend && rd_owner;
      if (!reset) begin
         case (state)
            CLEAR: begin
               mem_chipselect = 1'b1;
               mem_write      = 1'b1;
               mem_byteenable = '1;
               mem_address    = clr_cnt;
               if (clr_cnt == CLR_LAST) state_next = RUN;
            end
            RUN: begin
               if (grant_valid) begin
                  mem_chipselect = 1'b1;
                  if (grant_sel) begin
                     mem_address    = r1.address;
                     mem_byteenable = r1.byteenable;
                     mem_write      = r1.write;
                     mem_writedata  = r1.writedata;
                     r1.waitrequest = 1'b0;
                  end else begin
                     mem_address    = r0.address;
                     mem_byteenable = r0.byteenable;
                     mem_write      = r0.write;
                     mem_writedata  = r0.writedata;
                     r0.waitrequest = 1'b0;
                  end
               end
            end
            default: state_next = RUN;
         endcase
      end
   end

   // A pending read lasts exactly one cycle, matching the memory's one-cycle read latency
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
         clr_cnt    <= '0;
         last_grant <= 1'b1;
         rd_pend    <= 1'b0;
         rd_owner   <= 1'b0;
      end else begin
         state   <= state_next;
         rd_pend <= grant_valid && grant_is_read;
         if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
         if (grant_valid) begin
            rd_owner   <= grant_sel;
            last_grant <= grant_sel;
         end
      end
   end

endmodule

// File: tb/tb_nios2_onchip_mem_arbiter.sv
// Directed bench for the on-chip memory arbiter with a behavioural 2048x32 memory
// (registered address, combinational read data, byte-lane writes).
module tb_nios2_onchip_mem_arbiter;

   logic        clk;
   logic        reset;
   logic [10:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic        mem_clken;
   logic [31:0] mem_readdata;

   logic [31:0] mem_model [0:2047];
   logic [10:0] mem_addr_q;

   int passCount;
   int failCount;
   int totalCount;
   int clearBad;

   nios2_onchip_mem_arbiter_if #(.ADDR_W(11), .DATA_W(32), .BE_W(4)) r0_bus ();
   nios2_onchip_mem_arbiter_if #(.ADDR_W(11), .DATA_W(32), .BE_W(4)) r1_bus ();

   nios2_onchip_mem_arbiter #(
      .ADDR_W(11), .DATA_W(32), .BE_W(4), .DEPTH(2048), .CLEAR_ON_RESET(1)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .r0             (r0_bus.slave),
      .r1             (r1_bus.slave),
      .mem_address    (mem_address),
      .mem_byteenable (mem_byteenable),
      .mem_chipselect (mem_chipselect),
      .mem_write      (mem_write),
      .mem_writedata  (mem_writedata),
      .mem_clken      (mem_clken),
      .mem_readdata   (mem_readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents start as all ones so a successful zero-fill is observable
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 2048; i++) mem_model[i] <= 32'hFFFF_FFFF;
         mem_addr_q <= '0;
      end else if (mem_chipselect && mem_clken) begin
         if (mem_write)
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) mem_model[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
         mem_addr_q <= mem_address;
      end
   end

   assign mem_readdata = mem_model[mem_addr_q];

   task automatic applyStimulus(
      input logic rst,
      input logic a_rd, input logic a_wr, input logic [10:0] a_addr, input logic [3:0] a_be, input logic [31:0] a_wd,
      input logic b_rd, input logic b_wr, input logic [10:0] b_addr, input logic [3:0] b_be, input logic [31:0] b_wd
   );
      @(negedge clk);
      reset                = rst;
      r0_bus.read          = a_rd;
      r0_bus.write         = a_wr;
      r0_bus.address       = a_addr;
      r0_bus.byteenable    = a_be;
      r0_bus.writedata     = a_wd;
      r1_bus.read          = b_rd;
      r1_bus.write         = b_wr;
      r1_bus.address       = b_addr;
      r1_bus.byteenable    = b_be;
      r1_bus.writedata     = b_wd;
      #1;
   endtask

   task automatic holdCycle();
      @(negedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      totalCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      passCount  = 0;
      failCount  = 0;
      totalCount = 0;
      clearBad   = 0;
      reset      = 1'b1;
      r0_bus.read = 0; r0_bus.write = 0; r0_bus.address = '0; r0_bus.byteenable = '0; r0_bus.writedata = '0;
      r1_bus.read = 0; r1_bus.write = 0; r1_bus.address = '0; r1_bus.byteenable = '0; r1_bus.writedata = '0;

      // Reset held with a read pending on r0: nothing may be granted or returned
      applyStimulus(1, 1, 0, 11'd0, 4'hF, 32'h0, 0, 0, 11'd0, 4'h0, 32'h0);
      applyStimulus(1, 1, 0, 11'd0, 4'hF, 32'h0, 0, 0, 11'd0, 4'h0, 32'h0);
      checkOutput("rst_r0_wait", r0_bus.waitrequest, 1);
      checkOutput("rst_r1_wait", r1_bus.waitrequest, 1);
      checkOutput("rst_cs", mem_chipselect, 0);
      checkOutput("rst_wr", mem_write, 0);
      checkOutput("rst_r0_rdv", r0_bus.readdatavalid, 0);
      checkOutput("clken", mem_clken, 1);

      // Test 1: 2048 clear writes at consecutive addresses, then the held read is granted
      applyStimulus(0, 1, 0, 11'd0, 4'hF, 32'h0, 0, 0, 11'd0, 4'h0, 32'h0);
      for (int i = 0; i < 2048; i++) begin
         if (mem_chipselect !== 1'b1 || mem_write !== 1'b1 || mem_address !== 11'(i) ||
             mem_byteenable !== 4'hF || mem_writedata !== 32'h0 ||
             r0_bus.waitrequest !== 1'b1 || r0_bus.readdatavalid !== 1'b0)
            clearBad++;
         if (i != 2047) holdCycle();
      end
      checkOutput("clear_cycles_bad", clearBad, 0);
      holdCycle();
      checkOutput("t1_grant_r0_wait", r0_bus.waitrequest, 0);
      checkOutput("t1_grant_wr", mem_write, 0);
      checkOutput("t1_grant_cs", mem_chipselect, 1);
      applyStimulus(0, 0, 0, 11'd0, 4'h0, 32'h0, 0, 0, 11'd0, 4'h0, 32'h0);
      checkOutput("t1_r0_rdv", r0_bus.readdatavalid, 1);
      checkOutput("t1_r0_data", r0_bus.readdata, 32'h0);
      checkOutput("t1_r1_rdv", r1_bus.readdatavalid, 0);

      // Test 2: r0 writes, r1 reads it back
      applyStimulus(0, 0, 1, 11'd5, 4'hF, 32'hDEAD_BEEF, 0, 0, 11'd0, 4'h0, 32'h0);
      checkOutput("t2_wr_grant", r0_bus.waitrequest, 0);
      checkOutput("t2_mem_wr", mem_write, 1);
      applyStimulus(0, 0, 0, 11'd0, 4'h0, 32'h0, 1, 0, 11'd5, 4'hF, 32'h0);
      checkOutput("t2_r1_grant", r1_bus.waitrequest, 0);
      checkOutput("t2_r0_no_rdv", r0_bus.readdatavalid, 0);
      applyStimulus(0, 0, 0, 11'd0, 4'h0, 32'h0, 0, 0, 11'd0, 4'h0, 32'h0);
      checkOutput("t2_r1_rdv", r1_bus.readdatavalid, 1);
      checkOutput("t2_r1_data", r1_bus.readdata, 32'hDEAD_BEEF);
      checkOutput("t2_r0_rdv", r0_bus.readdatavalid, 0);

      // Test 3: seed addresses 10 and 20, then both read continuously
      applyStimulus(0, 0, 1, 11'd10, 4'hF, 32'h0A0A_0A0A, 0, 0, 11'd0, 4'h0, 32'h0);
      applyStimulus(0, 0, 0, 11'd0, 4'h0, 32'h0, 0, 1, 11'd20, 4'hF, 32'h1414_1414);
      applyStimulus(0, 1, 0, 11'd10, 4'hF, 32'h0, 1, 0, 11'd20, 4'hF, 32'h0);
      checkOutput("t3a_r0_grant", r0_bus.waitrequest, 0);
      checkOutput("t3a_r1_wait", r1_bus.waitrequest, 1);
      checkOutput("t3a_addr", mem_address, 11'd10);
      holdCycle();
      checkOutput("t3b_r1_grant", r1_bus.waitrequest, 0);
      checkOutput("t3b_r0_wait", r0_bus.waitrequest, 1);
      checkOutput("t3b_addr", mem_address, 11'd20);
      checkOutput("t3b_r0_rdv", r0_bus.readdatavalid, 1);
      checkOutput("t3b_r0_data", r0_bus.readdata, 32'h0A0A_0A0A);
      checkOutput("t3b_r1_rdv", r1_bus.readdatavalid, 0);
      holdCycle();
      checkOutput("t3c_r0_grant", r0_bus.waitrequest, 0);
      checkOutput("t3c_r1_rdv", r1_bus.readdatavalid, 1);
      checkOutput("t3c_r1_data", r1_bus.readdata, 32'h1414_1414);
      checkOutput("t3c_r0_rdv", r0_bus.readdatavalid, 0);
      holdCycle();
      checkOutput("t3d_r1_grant", r1_bus.waitrequest, 0);
      checkOutput("t3d_r0_rdv", r0_bus.readdatavalid, 1);
      applyStimulus(0, 0, 0, 11'd0, 4'h0, 32'h0, 0, 0, 11'd0, 4'h0, 32'h0);
      checkOutput("t3e_r1_rdv", r1_bus.readdatavalid, 1);
      checkOutput("t3e_idle_cs", mem_chipselect, 0);
      checkOutput("t3e_idle_r0_wait", r0_bus.waitrequest, 1);
      checkOutput("t3e_idle_r1_wait", r1_bus.waitrequest, 1);

      // Test 4: partial byte-lane overwrite by r1
      applyStimulus(0, 0, 0, 11'd0, 4'h0, 32'h0, 0, 1, 11'd7, 4'hF, 32'h1122_3344);
      applyStimulus(0, 0, 0, 11'd0, 4'h0, 32'h0, 0, 1, 11'd7, 4'h3, 32'hAABB_CCDD);
      checkOutput("t4_be", mem_byteenable, 4'h3);
      applyStimulus(0, 0, 0, 11'd0, 4'h0, 32'h0, 1, 0, 11'd7, 4'hF, 32'h0);
      applyStimulus(0, 0, 0, 11'd0, 4'h0, 32'h0, 0, 0, 11'd0, 4'h0, 32'h0);
      checkOutput("t4_r1_rdv", r1_bus.readdatavalid, 1);
      checkOutput("t4_r1_data", r1_bus.readdata, 32'h1122_CCDD);

      // Test 6: read+write together behaves as a write
      applyStimulus(0, 1, 1, 11'd3, 4'hF, 32'h5, 0, 0, 11'd0, 4'h0, 32'h0);
      checkOutput("t6_grant", r0_bus.waitrequest, 0);
      checkOutput("t6_mem_wr", mem_write, 1);
      applyStimulus(0, 0, 0, 11'd0, 4'h0, 32'h0, 0, 0, 11'd0, 4'h0, 32'h0);
      checkOutput("t6_no_rdv", r0_bus.readdatavalid, 0);
      applyStimulus(0, 1, 0, 11'd3, 4'hF, 32'h0, 0, 0, 11'd0, 4'h0, 32'h0);
      applyStimulus(0, 0, 0, 11'd0, 4'h0, 32'h0, 0, 0, 11'd0, 4'h0, 32'h0);
      checkOutput("t6_rdv", r0_bus.readdatavalid, 1);
      checkOutput("t6_data", r0_bus.readdata, 32'h5);

      // Test 5: reset right after a read grant drops the read and restarts the clear
      applyStimulus(0, 1, 0, 11'd0, 4'hF, 32'h0, 0, 0, 11'd0, 4'h0, 32'h0);
      checkOutput("t5_grant", r0_bus.waitrequest, 0);
      applyStimulus(1, 0, 0, 11'd0, 4'h0, 32'h0, 0, 0, 11'd0, 4'h0, 32'h0);
      checkOutput("t5_rst_rdv", r0_bus.readdatavalid, 0);
      checkOutput("t5_rst_cs", mem_chipselect, 0);
      applyStimulus(0, 0, 0, 11'd0, 4'h0, 32'h0, 0, 0, 11'd0, 4'h0, 32'h0);
      checkOutput("t5_clr_addr0", mem_address, 11'd0);
      checkOutput("t5_clr_wr", mem_write, 1);
      checkOutput("t5_post_rdv", r0_bus.readdatavalid, 0);
      holdCycle();
      checkOutput("t5_clr_addr1", mem_address, 11'd1);
      applyStimulus(1, 0, 0, 11'd0, 4'h0, 32'h0, 0, 0, 11'd0, 4'h0, 32'h0);
      applyStimulus(0, 0, 0, 11'd0, 4'h0, 32'h0, 0, 0, 11'd0, 4'h0, 32'h0);
      checkOutput("t5_restart_addr", mem_address, 11'd0);
      checkOutput("t5_restart_r0_wait", r0_bus.waitrequest, 1);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
